// File: rtl/mat_mult.sv
// Sequential 3x3 matrix multiplier: one C element per cycle, three multipliers.
// Define MAT_MULT_SIGNED_EN for two's-complement operands; unsigned by default.
module mat_mult #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 2*DATA_W+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mult_en,
  input  logic [9*DATA_W-1:0]  matrix_a_stream,
  input  logic [9*DATA_W-1:0]  matrix_b_stream,
  output logic [9*OUT_W-1:0]   matrix_c_stream,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {IDLE = 1'b0, COMPUTE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [9*DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OUT_W-1:0]      c_q [9];
  logic [OUT_W-1:0]      c_d [9];
  logic                  busy_q, busy_d, done_q, done_d;

  logic [DATA_W-1:0]     a_e [9];
  logic [DATA_W-1:0]     b_e [9];
  logic [3:0]            rb_s, cb_s;
  logic [OUT_W-1:0]      p0_s, p1_s, p2_s, dot_s;

  // Widening to OUT_W first keeps the low OUT_W product bits exact in both modes.
  function automatic logic [OUT_W-1:0] ext(input logic [DATA_W-1:0] v);
`ifdef MAT_MULT_SIGNED_EN
    ext = {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
`else
    ext = {{(OUT_W-DATA_W){1'b0}}, v};
`endif
  endfunction

  // Unpack latched operands into row-major element arrays.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      a_e[k] = a_q[(8-k)*DATA_W +: DATA_W];
      b_e[k] = b_q[(8-k)*DATA_W +: DATA_W];
    end
  end

  // Map the element index to the base index of A's row and B's column.
  always_comb begin
    rb_s = 4'd0;
    cb_s = 4'd0;
    case (idx_q)
      4'd0:    begin rb_s = 4'd0; cb_s = 4'd0; end
      4'd1:    begin rb_s = 4'd0; cb_s = 4'd1; end
      4'd2:    begin rb_s = 4'd0; cb_s = 4'd2; end
      4'd3:    begin rb_s = 4'd3; cb_s = 4'd0; end
      4'd4:    begin rb_s = 4'd3; cb_s = 4'd1; end
      4'd5:    begin rb_s = 4'd3; cb_s = 4'd2; end
      4'd6:    begin rb_s = 4'd6; cb_s = 4'd0; end
      4'd7:    begin rb_s = 4'd6; cb_s = 4'd1; end
      4'd8:    begin rb_s = 4'd6; cb_s = 4'd2; end
      default: begin rb_s = 4'd0; cb_s = 4'd0; end
    endcase
  end

  // Dot product of the selected row and column.
  always_comb begin
    p0_s  = ext(a_e[rb_s])        * ext(b_e[cb_s]);
    p1_s  = ext(a_e[rb_s + 4'd1]) * ext(b_e[cb_s + 4'd3]);
    p2_s  = ext(a_e[rb_s + 4'd2]) * ext(b_e[cb_s + 4'd6]);
    dot_s = p0_s + p1_s + p2_s;
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mult_en) begin
          a_d     = matrix_a_stream;
          b_d     = matrix_b_stream;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = COMPUTE;
        end else begin
          busy_d  = 1'b0;
        end
      end
      COMPUTE: begin
        c_d[idx_q] = dot_s;
        if (idx_q == 4'd8) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      a_q     <= {(9*DATA_W){1'b0}};
      b_q     <= {(9*DATA_W){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 9; k++) c_q[k] <= {OUT_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int k = 0; k < 9; k++) c_q[k] <= c_d[k];
    end
  end

  // Pack the result registers, C[0][0] at the MSBs.
  always_comb begin
    for (int k = 0; k < 9; k++) matrix_c_stream[(8-k)*OUT_W +: OUT_W] = c_q[k];
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mat_mult.sv
// Self-checking bench for mat_mult against a plain-arithmetic matrix model.
// Also exercises signed mode when MAT_MULT_SIGNED_EN is defined.
module tb_mat_mult;
  localparam int DW = 16;
  localparam int OW = 2*DW+2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mult_en = 1'b0;
  logic [9*DW-1:0] a_bus = '0;
  logic [9*DW-1:0] b_bus = '0;
  logic [9*OW-1:0] c_bus;
  logic            busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] a_m [9];
  logic [DW-1:0] b_m [9];

  mat_mult #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .mult_en(mult_en),
    .matrix_a_stream(a_bus), .matrix_b_stream(b_bus),
    .matrix_c_stream(c_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic longint val(input logic [DW-1:0] x);
`ifdef MAT_MULT_SIGNED_EN
    val = longint'($signed(x));
`else
    val = longint'({48'd0, x});
`endif
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j], truncated to OW bits (never needed in range).
  function automatic logic [9*OW-1:0] model(input logic [DW-1:0] a[9], input logic [DW-1:0] b[9]);
    logic [9*OW-1:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += val(a[i*3+k]) * val(b[k*3+j]);
        r[(8-(i*3+j))*OW +: OW] = s[OW-1:0];
      end
    return r;
  endfunction

  function automatic logic [9*DW-1:0] pack(input logic [DW-1:0] m[9]);
    logic [9*DW-1:0] r;
    for (int k = 0; k < 9; k++) r[(8-k)*DW +: DW] = m[k];
    return r;
  endfunction

  task automatic set_basic();
    for (int k = 0; k < 9; k++) begin
      a_m[k] = DW'(k + 1);
      b_m[k] = DW'(k + 10);
    end
  endtask

  // Pulse mult_en for one edge, then watch a window of edges after the start edge.
  task automatic run_op(output int first_done, output int n_done, output int n_busy);
    a_bus = pack(a_m);
    b_bus = pack(b_m);
    mult_en = 1'b1;
    @(posedge clk); #1;
    mult_en = 1'b0;
    first_done = -1; n_done = 0; n_busy = busy ? 1 : 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = e;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (c_bus !== '0) begin n_err++; $display("FAIL reset_c: got %h want 0", c_bus); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [OW-1:0] exp_e [9];
    logic [9*OW-1:0] exp_c;
    int fd, nd, nb;
    exp_e = '{34'd84, 34'd90, 34'd96, 34'd201, 34'd216, 34'd231, 34'd318, 34'd342, 34'd366};
    for (int k = 0; k < 9; k++) exp_c[(8-k)*OW +: OW] = exp_e[k];
    set_basic();
    run_op(fd, nd, nb);
    n_cmp++; if (fd !== 9) begin n_err++; $display("FAIL basic_latency: got %0d edges want 9", fd); end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_cmp++; if (nb !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 9", nb); end
    n_cmp++; if (c_bus !== exp_c) begin n_err++; $display("FAIL basic_c: got %h want %h", c_bus, exp_c); end
  endtask

  task automatic test_identity();
    int fd, nd, nb;
    logic [9*OW-1:0] exp_c;
    for (int k = 0; k < 9; k++) begin
      a_m[k] = (k % 4 == 0) ? 16'd1 : 16'd0;
      b_m[k] = DW'(k + 10);
    end
    for (int k = 0; k < 9; k++) exp_c[(8-k)*OW +: OW] = {18'd0, b_m[k]};
    run_op(fd, nd, nb);
    n_cmp++; if (c_bus !== exp_c) begin n_err++; $display("FAIL identity_c: got %h want %h", c_bus, exp_c); end
  endtask

  task automatic test_full_scale();
    int fd, nd, nb;
    logic [OW-1:0] e;
    for (int k = 0; k < 9; k++) begin a_m[k] = 16'hFFFF; b_m[k] = 16'hFFFF; end
`ifdef MAT_MULT_SIGNED_EN
    e = 34'd3;
`else
    e = 34'd12884508675;
`endif
    run_op(fd, nd, nb);
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (c_bus[(8-k)*OW +: OW] !== e) begin
        n_err++; $display("FAIL full_scale_c%0d: got %0d want %0d", k, c_bus[(8-k)*OW +: OW], e);
      end
    end
  endtask

  task automatic test_random();
    int fd, nd, nb;
    logic [9*OW-1:0] exp_c;
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 9; k++) begin
        a_m[k] = DW'($urandom);
        b_m[k] = DW'($urandom);
      end
      exp_c = model(a_m, b_m);
      run_op(fd, nd, nb);
      n_cmp++; if (c_bus !== exp_c) begin n_err++; $display("FAIL random_c[%0d]: got %h want %h", t, c_bus, exp_c); end
      n_cmp++; if (fd !== 9) begin n_err++; $display("FAIL random_latency[%0d]: got %0d want 9", t, fd); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [9*OW-1:0] exp_c;
    int nd;
    set_basic();
    exp_c = model(a_m, b_m);
    a_bus = pack(a_m); b_bus = pack(b_m);
    mult_en = 1'b1;
    @(posedge clk); #1;
    mult_en = 1'b0;
    nd = 0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 3) begin a_bus = '0; b_bus = '0; mult_en = 1'b1; end
      if (e == 4) mult_en = 1'b0;
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_cmp++; if (c_bus !== exp_c) begin n_err++; $display("FAIL busy_ignore_c: got %h want %h", c_bus, exp_c); end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL busy_ignore_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_mid_reset();
    int nd;
    set_basic();
    a_bus = pack(a_m); b_bus = pack(b_m);
    mult_en = 1'b1;
    @(posedge clk); #1;
    mult_en = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (c_bus !== '0) begin n_err++; $display("FAIL mid_reset_c: got %h want 0", c_bus); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    nd = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", nd); end
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    logic [9*OW-1:0] exp_c;
    int waited;
    for (int k = 0; k < 9; k++) begin a_m[k] = DW'($urandom); b_m[k] = DW'($urandom); end
    exp_c = model(a_m, b_m);
    a_bus = pack(a_m); b_bus = pack(b_m);
    mult_en = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clk); #1;
      if (done) pulses.push_back(e);
    end
    mult_en = 1'b0;
    n_cmp++; if (pulses.size() !== 3) begin n_err++; $display("FAIL b2b_pulse_count: got %0d want 3", pulses.size()); end
    if (pulses.size() >= 2) begin
      for (int p = 1; p < pulses.size(); p++) begin
        n_cmp++;
        if (pulses[p] - pulses[p-1] !== 10) begin
          n_err++; $display("FAIL b2b_period: got %0d want 10", pulses[p] - pulses[p-1]);
        end
      end
    end
    waited = 0;
    while (busy && waited < 30) begin @(posedge clk); #1; waited++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_timeout: busy=%b want 0", busy); end
    n_cmp++; if (c_bus !== exp_c) begin n_err++; $display("FAIL b2b_c: got %h want %h", c_bus, exp_c); end
  endtask

`ifdef MAT_MULT_SIGNED_EN
  task automatic test_signed();
    int fd, nd, nb;
    logic [OW-1:0] exp_row [3];
    exp_row[0] = -34'sd39; exp_row[1] = -34'sd42; exp_row[2] = -34'sd45;
    for (int k = 0; k < 9; k++) begin a_m[k] = 16'hFFFF; b_m[k] = DW'(k + 10); end
    run_op(fd, nd, nb);
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (c_bus[(8-k)*OW +: OW] !== exp_row[k%3]) begin
        n_err++; $display("FAIL signed_c%0d: got %h want %h", k, c_bus[(8-k)*OW +: OW], exp_row[k%3]);
      end
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_identity();
    test_full_scale();
    test_random();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
`ifdef MAT_MULT_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
